// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the memory responder slice.
//            Holds the responder FSM state encoding and the byte-offset mask
//            that identifies misaligned word accesses.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Responder FSM states. Encoding is fixed so waveforms read consistently.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    // Any bit set under this mask in a byte address means the access is not
    // word aligned.
    localparam logic [31:0] c_word_align_mask = 32'h0000_0003;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_array
// Purpose  : DEPTH x 32-bit word storage. Synchronous write, combinational
//            read at the same index. Contents are never reset.
// Ports    : clk      - rising-edge clock
//            i_we     - write enable, write occurs at the clock edge
//            i_addr   - word index used for both read and write
//            i_wdata  - write data
//            o_rdata  - read data at i_addr (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Word-addressed memory responder with a fixed access latency.
//            Accepts one request at a time on a valid/ready request channel,
//            spends LATENCY cycles in BUSY, performs the access, and presents
//            the result on a valid/ready response channel.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-low reset
//            req_valid  - request present
//            req_ready  - responder can accept (IDLE only)
//            req_we     - 1 = store, 0 = load
//            req_addr   - byte address, word index = req_addr[31:2]
//            req_wdata  - store data
//            rsp_valid  - response present (RESP only)
//            rsp_ready  - requester consumes response
//            rsp_rdata  - load data; 0 for stores and errors
//            rsp_err    - misaligned or out-of-range access
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);

    mem_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;

    // Request captured at the accept edge; the live request inputs are
    // ignored from then on until the FSM is back in IDLE.
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [29:0]        w_word_idx;
    logic               w_misaligned;
    logic               w_out_of_range;
    logic               w_err;
    logic               w_access;
    logic               w_mem_we;
    logic [31:0]        w_mem_rdata;

    assign w_word_idx     = r_addr[31:2];
    assign w_misaligned   = |(r_addr & c_word_align_mask);
    // Compare the full 30-bit index so high address bits cannot alias into
    // the array.
    assign w_out_of_range = (w_word_idx >= 30'(DEPTH));
    assign w_err          = w_misaligned | w_out_of_range;

    // The access happens on the last BUSY edge. Gating the write with the
    // state means an asynchronous reset during BUSY cancels the store.
    assign w_access       = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_mem_we       = w_access && r_we && !w_err;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (r_addr[c_aw+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= c_cnt_init;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_we) ? 32'h0 : w_mem_rdata;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Response payload is held until consumed; req_ready
                    // only rises after the handshake edge, so a request
                    // waiting here is accepted one edge later.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule : mem_responder
`default_nettype wire
